// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for the CPU data port.
// Word-addressed 16-bit array with a programmable access latency and a
// small IDLE -> ACCESS -> RESP request FSM. Define DMEM_MMIO_EN to map the
// full address 16'hFFFF onto the io_in/io_out port instead of the array.
module data_mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        proto_err,
    input  logic [15:0] io_in,
    output logic [15:0] io_out
);

    localparam int         DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] LAT4  = LATENCY[3:0];

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // The down-counter is 4 bits wide and a zero latency has no completion edge.
    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("data_mem_responder: LATENCY must be within 1..15");
        end
    endgenerate

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [15:0]       addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              store_q, store_d;
    logic              err_q, err_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              perr_q, perr_d;

    logic [15:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic              complete;
    logic              is_io;
    logic              mem_we;

    assign idx      = addr_q[ADDR_W-1:0];
    assign complete = (state_q == ST_ACCESS) && (cnt_q == 4'd1);
    assign mem_we   = complete && store_q && !is_io;

`ifdef DMEM_MMIO_EN
    logic [15:0] io_out_q, io_out_d;

    // Only the exact full-width address selects the I/O word; no aliasing.
    assign is_io  = (addr_q == 16'hFFFF);
    assign io_out = io_out_q;
`else
    logic unused_inputs;

    assign is_io         = 1'b0;
    assign io_out        = 16'h0000;
    assign unused_inputs = ^{io_in, addr_q};
`endif

    assign rdata     = rdata_q;
    assign ready     = ready_q;
    assign proto_err = perr_q;
    assign busy      = (state_q != ST_IDLE);

    // Next-state logic: capture in IDLE, count down in ACCESS, one-cycle RESP.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        store_d  = store_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        ready_d  = 1'b0;
        perr_d   = 1'b0;
`ifdef DMEM_MMIO_EN
        io_out_d = io_out_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (mem_r || mem_w) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    store_d = mem_w;            // a dual request is a store
                    err_d   = mem_r && mem_w;
                    cnt_d   = LAT4;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd1) begin
                    if (!store_q) begin
                        rdata_d = is_io ? io_in : mem_q[idx];
                    end
`ifdef DMEM_MMIO_EN
                    if (store_q && is_io) begin
                        io_out_d = wdata_q;
                    end
`endif
                    ready_d = 1'b1;
                    perr_d  = err_q;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and response registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            store_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 16'h0000;
            ready_q  <= 1'b0;
            perr_q   <= 1'b0;
`ifdef DMEM_MMIO_EN
            io_out_q <= 16'h0000;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            store_q  <= store_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            ready_q  <= ready_d;
            perr_q   <= perr_d;
`ifdef DMEM_MMIO_EN
            io_out_q <= io_out_d;
`endif
        end
    end

    // Array write port; contents survive reset because the FSM is forced idle.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: drives two responders (LATENCY 2 and 3) with shared
// inputs and reset, checks handshake timing and data against an array model.
`timescale 1ns/1ps
module tb_data_mem_responder;

`ifdef DMEM_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_r = 1'b0;
    logic        mem_w = 1'b0;
    logic [15:0] addr = 16'h0;
    logic [15:0] wdata = 16'h0;
    logic [15:0] io_in = 16'h0;

    logic [15:0] rdata2, io_out2, rdata3, io_out3;
    logic        ready2, busy2, perr2, ready3, busy3, perr3;

    int tests = 0;
    int failed = 0;

    // Reference state: plain array contents, last load value, I/O register.
    logic [15:0] m_mem [256];
    logic [15:0] m_rdata = 16'h0;
    logic [15:0] m_io = 16'h0;

    data_mem_responder #(.ADDR_W(8), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .mem_r(mem_r), .mem_w(mem_w),
        .addr(addr), .wdata(wdata), .rdata(rdata2), .ready(ready2),
        .busy(busy2), .proto_err(perr2), .io_in(io_in), .io_out(io_out2)
    );

    data_mem_responder #(.ADDR_W(8), .LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .mem_r(mem_r), .mem_w(mem_w),
        .addr(addr), .wdata(wdata), .rdata(rdata3), .ready(ready3),
        .busy(busy3), .proto_err(perr3), .io_in(io_in), .io_out(io_out3)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Apply one request to the reference model.
    task automatic model_apply(input logic w, input logic [15:0] a, wd, iv);
        bit io_hit;
        io_hit = MMIO && (a == 16'hFFFF);
        if (w) begin
            if (io_hit) m_io = wd;
            else        m_mem[a[7:0]] = wd;
        end else begin
            if (io_hit) m_rdata = iv;
            else        m_rdata = m_mem[a[7:0]];
        end
    endtask

    // One full transaction; sel picks which instance's outputs are checked.
    task automatic txn(input bit sel, input logic r, w, input logic [15:0] a, wd, iv,
                       input bit quiet,
                       output logic [15:0] rd_o, output logic [15:0] io_o, output logic err_o);
        int lat;
        int n;
        bit got;
        logic o_ready, o_busy, o_err;
        lat = sel ? 3 : 2;
        @(posedge clk); #1;
        mem_r = r; mem_w = w; addr = a; wdata = wd; io_in = iv;
        @(posedge clk); #1;
        mem_r = 1'b0; mem_w = 1'b0;
        model_apply(w, a, wd, iv);
        n = 0; got = 0;
        rd_o = 16'h0; io_o = 16'h0; err_o = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            o_ready = sel ? ready3 : ready2;
            o_busy  = sel ? busy3 : busy2;
            o_err   = sel ? perr3 : perr2;
            chk("busy_in_flight", {31'd0, o_busy}, 32'd1);
            if (o_ready) begin
                got   = 1;
                rd_o  = sel ? rdata3 : rdata2;
                io_o  = sel ? io_out3 : io_out2;
                err_o = o_err;
            end else begin
                chk("perr_before_ready", {31'd0, o_err}, 32'd0);
            end
        end
        chk("ready_latency", got ? n : 99, lat + 1);
        chk("proto_err", {31'd0, err_o}, {31'd0, r & w});
        chk("rdata", {16'd0, rd_o}, {16'd0, m_rdata});
        chk("io_out", {16'd0, io_o}, {16'd0, m_io});
        @(negedge clk);
        chk("ready_one_cycle", {31'd0, sel ? ready3 : ready2}, 32'd0);
        chk("perr_one_cycle", {31'd0, sel ? perr3 : perr2}, 32'd0);
        chk("busy_after_resp", {31'd0, sel ? busy3 : busy2}, 32'd0);
        n = 0;
        while ((busy2 || busy3) && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("both_idle", {30'd0, busy2, busy3}, 32'd0);
        if (!quiet)
            $display("[TB] txn sel=%0d r=%0d w=%0d addr=%h wdata=%h io_in=%h -> rdata=%h io_out=%h perr=%0d",
                     sel, r, w, a, wd, iv, rd_o, io_o, err_o);
    endtask

    // Store that is aborted by a reset pulse edges_after edges past capture.
    task automatic abort_txn(input logic [15:0] a, wd, input int edges_after);
        @(posedge clk); #1;
        mem_w = 1'b1; addr = a; wdata = wd;
        @(posedge clk); #1;
        mem_w = 1'b0;
        repeat (edges_after) @(posedge clk);
        #2;
        chk("abort_busy_pre", {30'd0, busy2, busy3}, 32'd3);
        reset = 1'b0;
        #1;
        chk("async_rdata", {rdata2, rdata3}, 32'd0);
        chk("async_ready", {30'd0, ready2, ready3}, 32'd0);
        chk("async_busy", {30'd0, busy2, busy3}, 32'd0);
        chk("async_perr", {30'd0, perr2, perr3}, 32'd0);
        chk("async_io_out", {io_out2, io_out3}, 32'd0);
        m_rdata = 16'h0;
        m_io = 16'h0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_ready", {30'd0, ready2, ready3}, 32'd0);
        end
        $display("[TB] txn aborted store addr=%h wdata=%h by reset", a, wd);
    endtask

    typedef struct {
        logic        sel;
        logic        r;
        logic        w;
        logic [15:0] a;
        logic [15:0] wd;
        logic [15:0] iv;
        logic [15:0] exp_rd;
        logic [15:0] exp_io;
        logic        exp_err;
    } vec_t;

    vec_t vt[9];

    initial begin
        logic [15:0] rd, io;
        logic        er;
        logic [7:0]  b;
        int          k;
        logic [15:0] ra;

        // Directed vectors; the array holds {i, ~i} in word i before these run.
        vt[0] = '{1'b0, 1'b0, 1'b1, 16'h0005, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        vt[1] = '{1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 1'b0};
        vt[2] = '{1'b1, 1'b0, 1'b1, 16'h0103, 16'hBEEF, 16'h0000, 16'h1234, 16'h0000, 1'b0};
        vt[3] = '{1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 1'b0};
        vt[4] = '{1'b0, 1'b1, 1'b1, 16'h0010, 16'hAAAA, 16'h0000, 16'hBEEF, 16'h0000, 1'b1};
        vt[5] = '{1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0000, 16'hAAAA, 16'h0000, 1'b0};
        vt[6] = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h00C3, 16'h0000, 16'hAAAA,
                  MMIO ? 16'h00C3 : 16'h0000, 1'b0};
        vt[7] = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0F0F,
                  MMIO ? 16'h0F0F : 16'h00C3, MMIO ? 16'h00C3 : 16'h0000, 1'b0};
        vt[8] = '{1'b0, 1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h0F0F,
                  MMIO ? 16'hFF00 : 16'h00C3, MMIO ? 16'h00C3 : 16'h0000, 1'b0};

        // Reset state
        #3;
        chk("reset_rdata", {rdata2, rdata3}, 32'd0);
        chk("reset_flags", {26'd0, ready2, ready3, busy2, busy3, perr2, perr3}, 32'd0);
        chk("reset_io_out", {io_out2, io_out3}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Fill the array with a known pattern so every later load is predictable.
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            txn(1'b0, 1'b0, 1'b1, {8'h00, b}, {b, ~b}, 16'h0, 1'b1, rd, io, er);
        end

        // Directed table
        for (int i = 0; i < 9; i++) begin
            txn(vt[i].sel, vt[i].r, vt[i].w, vt[i].a, vt[i].wd, vt[i].iv, 1'b0, rd, io, er);
            chk($sformatf("vec%0d_rdata", i), {16'd0, rd}, {16'd0, vt[i].exp_rd});
            chk($sformatf("vec%0d_io_out", i), {16'd0, io}, {16'd0, vt[i].exp_io});
            chk($sformatf("vec%0d_perr", i), {31'd0, er}, {31'd0, vt[i].exp_err});
        end

        // Reset mid-ACCESS: the LATENCY=3 instance sits at cnt=2 after one edge.
        txn(1'b1, 1'b0, 1'b1, 16'h0020, 16'h0000, 16'h0, 1'b0, rd, io, er);
        txn(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'h0, 1'b0, rd, io, er);
        abort_txn(16'h0020, 16'h5555, 1);
        txn(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0, 1'b0, rd, io, er);
        chk("abort_no_commit", {16'd0, rd}, 32'h0000_0000);
        txn(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0, 1'b0, rd, io, er);
        chk("abort_no_commit_l2", {16'd0, rd}, 32'h0000_0000);

        // Randomized traffic against the model
        for (int i = 0; i < 60; i++) begin
            k  = $urandom_range(1, 3);
            ra = $urandom_range(0, 7) == 0 ? 16'hFFFF : 16'($urandom);
            txn(1'($urandom_range(0, 1)), k[0], k[1], ra, 16'($urandom), 16'($urandom),
                1'b0, rd, io, er);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
